// File: rtl/sequencer_datapath.sv
// Microprogram sequencer datapath: PC, R, Y registers, operand adder and
// LIFO return stack with entry count and sticky overflow/underflow flags.
//
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   rst               : control-level clear, same effect as reset
//   d_in              : direct data/branch operand D
//   cen               : adder carry-in
//   a_mux_sel         : A operand (00 R, 01 stack top, 1x zero)
//   b_mux_sel         : B operand (00 PC, 01 stack top, 10 zero, 11 D)
//   rsel, rce         : R source (1 sum, 0 D) and load enable
//   out_ce, oen       : Y load enable and y_out output enable
//   inc, pc_mux_sel   : PC increment and source (1 incrementer, 0 stack/hold)
//   src_sel           : with pc_mux_sel=0, 1 loads PC from stack top
//   push/stack_we     : push request and its qualifying strobe
//   pop/stack_re      : pop request and its qualifying strobe
//   y_out             : oen ? Y : 0
//   pc_out, r_out     : current PC and R
//   sp_out            : stack entry count
//   stack_empty/full  : count is 0 / DEPTH
//   overflow          : sticky, push attempted while full
//   underflow         : sticky, pop attempted while empty
module sequencer_datapath #(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    parameter int SPW   = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [AW-1:0]  d_in,
    input  logic           cen,
    input  logic           rst,
    input  logic           oen,
    input  logic           inc,
    input  logic           rsel,
    input  logic           rce,
    input  logic           pc_mux_sel,
    input  logic [1:0]     a_mux_sel,
    input  logic [1:0]     b_mux_sel,
    input  logic           push,
    input  logic           pop,
    input  logic           src_sel,
    input  logic           stack_we,
    input  logic           stack_re,
    input  logic           out_ce,
    output logic [AW-1:0]  y_out,
    output logic [AW-1:0]  pc_out,
    output logic [AW-1:0]  r_out,
    output logic [SPW-1:0] sp_out,
    output logic           stack_empty,
    output logic           stack_full,
    output logic           overflow,
    output logic           underflow
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] FULL_SP = SPW'(DEPTH);

    logic [AW-1:0]  pc_q, pc_d;
    logic [AW-1:0]  r_q, r_d;
    logic [AW-1:0]  y_q, y_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0]  stk_q [DEPTH];
    logic [AW-1:0]  stk_d [DEPTH];
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;

    logic [SPW-1:0] top_idx;
    logic [AW-1:0]  top;
    logic [AW-1:0]  a_op;
    logic [AW-1:0]  b_op;
    logic [AW-1:0]  sum;
    logic           empty;
    logic           full;
    logic           epush;
    logic           epop;

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == FULL_SP);
    assign top_idx = sp_q - SPW'(1);
    // An empty stack presents zero as its top.
    assign top     = empty ? '0 : stk_q[top_idx[IW-1:0]];
    assign epush   = push & stack_we;
    assign epop    = pop & stack_re;

    always_comb begin
        a_op = '0;
        unique case (a_mux_sel)
            2'b00:   a_op = r_q;
            2'b01:   a_op = top;
            default: a_op = '0;
        endcase
    end

    always_comb begin
        b_op = '0;
        unique case (b_mux_sel)
            2'b00:   b_op = pc_q;
            2'b01:   b_op = top;
            2'b10:   b_op = '0;
            default: b_op = d_in;
        endcase
    end

    // Carry-out is discarded; the sum wraps at AW bits.
    assign sum = a_op + b_op + {{(AW-1){1'b0}}, cen};

    always_comb begin
        pc_d  = pc_q;
        r_d   = r_q;
        y_d   = y_q;
        sp_d  = sp_q;
        stk_d = stk_q;
        ovf_d = ovf_q;
        unf_d = unf_q;

        if (out_ce) begin
            y_d = sum;
        end
        if (rce) begin
            r_d = rsel ? sum : d_in;
        end

        if (pc_mux_sel) begin
            pc_d = pc_q + {{(AW-1){1'b0}}, inc};
        end else if (src_sel) begin
            pc_d = top;
        end

        if (epush && epop) begin
            // Simultaneous push/pop replaces the top; on empty it is a push.
            if (empty) begin
                stk_d[sp_q[IW-1:0]] = pc_q;
                sp_d = sp_q + SPW'(1);
            end else begin
                stk_d[top_idx[IW-1:0]] = pc_q;
            end
        end else if (epush) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                stk_d[sp_q[IW-1:0]] = pc_q;
                sp_d = sp_q + SPW'(1);
            end
        end else if (epop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                sp_d = top_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || rst) begin
            pc_q  <= '0;
            r_q   <= '0;
            y_q   <= '0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            r_q   <= r_d;
            y_q   <= y_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            for (int i = 0; i < DEPTH; i++) begin
                stk_q[i] <= stk_d[i];
            end
        end
    end

    assign y_out       = oen ? y_q : '0;
    assign pc_out      = pc_q;
    assign r_out       = r_q;
    assign sp_out      = sp_q;
    assign stack_empty = empty;
    assign stack_full  = full;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_sequencer_datapath.sv
// Directed self-checking bench for sequencer_datapath.
// Each task drives one scenario and compares outputs inline.
module tb_sequencer_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d_in;
    logic       cen, rst, oen, inc, rsel, rce, pc_mux_sel;
    logic [1:0] a_mux_sel, b_mux_sel;
    logic       push, pop, src_sel, stack_we, stack_re, out_ce;
    logic [7:0] y_out, pc_out, r_out;
    logic [2:0] sp_out;
    logic       stack_empty, stack_full, overflow, underflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sequencer_datapath #(.AW(8), .DEPTH(4), .SPW(3)) dut (
        .clk(clk), .reset(reset), .d_in(d_in), .cen(cen), .rst(rst),
        .oen(oen), .inc(inc), .rsel(rsel), .rce(rce),
        .pc_mux_sel(pc_mux_sel), .a_mux_sel(a_mux_sel),
        .b_mux_sel(b_mux_sel), .push(push), .pop(pop),
        .src_sel(src_sel), .stack_we(stack_we), .stack_re(stack_re),
        .out_ce(out_ce), .y_out(y_out), .pc_out(pc_out), .r_out(r_out),
        .sp_out(sp_out), .stack_empty(stack_empty),
        .stack_full(stack_full), .overflow(overflow),
        .underflow(underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctl();
        d_in = 8'h00; cen = 0; rst = 0; oen = 0; inc = 0;
        rsel = 0; rce = 0; pc_mux_sel = 0; a_mux_sel = 2'b00;
        b_mux_sel = 2'b00; push = 0; pop = 0; src_sel = 0;
        stack_we = 0; stack_re = 0; out_ce = 0;
    endtask

    task automatic do_reset();
        clr_ctl();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            {cen, rst, oen, inc, rsel, rce, pc_mux_sel, push, pop,
             src_sel, stack_we, stack_re, out_ce} = 13'($urandom);
            a_mux_sel = 2'($urandom);
            b_mux_sel = 2'($urandom);
            d_in      = 8'($urandom);
            tick();
        end
        reset = 0;
        clr_ctl();
        oen = 1;
        #1;
        checks++;
        if (pc_out !== 8'h00) begin
            failures++; $display("FAIL reset_pc got=%0h exp=0", pc_out);
        end
        checks++;
        if (r_out !== 8'h00) begin
            failures++; $display("FAIL reset_r got=%0h exp=0", r_out);
        end
        checks++;
        if (y_out !== 8'h00) begin
            failures++; $display("FAIL reset_y got=%0h exp=0", y_out);
        end
        checks++;
        if ({sp_out, stack_empty, stack_full, overflow, underflow}
            !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_stack got sp=%0d e=%b f=%b o=%b u=%b exp sp=0 e=1 f=0 o=0 u=0",
                     sp_out, stack_empty, stack_full, overflow, underflow);
        end
        oen = 0;
    endtask

    task automatic test_fetch_pc();
        clr_ctl();
        pc_mux_sel = 1; inc = 1;
        repeat (3) tick();
        checks++;
        if (pc_out !== 8'h03) begin
            failures++; $display("FAIL fetch_pc3 got=%0h exp=3", pc_out);
        end
        a_mux_sel = 2'b10; b_mux_sel = 2'b00;
        rsel = 1; rce = 1; out_ce = 1; oen = 1;
        tick();
        checks++;
        if (r_out !== 8'h03) begin
            failures++; $display("FAIL fetch_r got=%0h exp=3", r_out);
        end
        checks++;
        if (y_out !== 8'h03) begin
            failures++; $display("FAIL fetch_y got=%0h exp=3", y_out);
        end
        checks++;
        if (pc_out !== 8'h04) begin
            failures++; $display("FAIL fetch_pc4 got=%0h exp=4", pc_out);
        end
        clr_ctl();
    endtask

    task automatic test_adder_wrap();
        clr_ctl();
        d_in = 8'h10; a_mux_sel = 2'b00; b_mux_sel = 2'b11; cen = 1;
        rsel = 1; rce = 1; out_ce = 1; oen = 1;
        tick();
        checks++;
        if (r_out !== 8'h14) begin
            failures++; $display("FAIL add_r got=%0h exp=14", r_out);
        end
        checks++;
        if (y_out !== 8'h14) begin
            failures++; $display("FAIL add_y got=%0h exp=14", y_out);
        end
        checks++;
        if (pc_out !== 8'h04) begin
            failures++; $display("FAIL add_pc_hold got=%0h exp=4", pc_out);
        end
        clr_ctl();
        d_in = 8'hFF; rce = 1; rsel = 0;
        tick();
        checks++;
        if (r_out !== 8'hFF) begin
            failures++; $display("FAIL load_r_d got=%0h exp=ff", r_out);
        end
        d_in = 8'h00; a_mux_sel = 2'b00; b_mux_sel = 2'b11; cen = 1;
        rsel = 1; rce = 1; out_ce = 1; oen = 1;
        tick();
        checks++;
        if (r_out !== 8'h00) begin
            failures++; $display("FAIL wrap_r got=%0h exp=0", r_out);
        end
        clr_ctl();
        pc_mux_sel = 1; inc = 1;
        repeat (251) tick();
        checks++;
        if (pc_out !== 8'hFF) begin
            failures++; $display("FAIL pc_ff got=%0h exp=ff", pc_out);
        end
        tick();
        checks++;
        if (pc_out !== 8'h00) begin
            failures++; $display("FAIL pc_wrap got=%0h exp=0", pc_out);
        end
        clr_ctl();
    endtask

    task automatic test_idle();
        do_reset();
        d_in = 8'h21; rce = 1; out_ce = 1;
        a_mux_sel = 2'b10; b_mux_sel = 2'b11;
        tick();
        clr_ctl();
        repeat (3) tick();
        checks++;
        if ({pc_out, r_out, sp_out, y_out} !== {8'h00, 8'h21, 3'd0, 8'h00}) begin
            failures++;
            $display("FAIL idle_hold got pc=%0h r=%0h sp=%0d y=%0h exp pc=0 r=21 sp=0 y=0",
                     pc_out, r_out, sp_out, y_out);
        end
        oen = 1;
        #1;
        checks++;
        if (y_out !== 8'h21) begin
            failures++; $display("FAIL idle_y_oen got=%0h exp=21", y_out);
        end
        clr_ctl();
    endtask

    task automatic test_stack_fill();
        do_reset();
        pc_mux_sel = 1; inc = 1;
        push = 1; stack_we = 0;
        tick();
        checks++;
        if (sp_out !== 3'd0 || pc_out !== 8'h01) begin
            failures++;
            $display("FAIL push_unqualified got sp=%0d pc=%0h exp sp=0 pc=1",
                     sp_out, pc_out);
        end
        stack_we = 1;
        repeat (4) tick();
        checks++;
        if ({sp_out, stack_full, stack_empty, overflow} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL fill got sp=%0d f=%b e=%b o=%b exp sp=4 f=1 e=0 o=0",
                     sp_out, stack_full, stack_empty, overflow);
        end
        checks++;
        if (pc_out !== 8'h05) begin
            failures++; $display("FAIL fill_pc got=%0h exp=5", pc_out);
        end
        pc_mux_sel = 0; inc = 0;
        tick();
        checks++;
        if ({sp_out, overflow, underflow} !== {3'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL overflow got sp=%0d o=%b u=%b exp sp=4 o=1 u=0",
                     sp_out, overflow, underflow);
        end
        clr_ctl();
    endtask

    task automatic test_return_underflow();
        logic [7:0] exp_pc;
        clr_ctl();
        pop = 1; stack_re = 0; src_sel = 1; pc_mux_sel = 0;
        tick();
        checks++;
        if (sp_out !== 3'd4 || pc_out !== 8'h04) begin
            failures++;
            $display("FAIL pop_unqualified got sp=%0d pc=%0h exp sp=4 pc=4",
                     sp_out, pc_out);
        end
        stack_re = 1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 8'(4 - i);
            tick();
            checks++;
            if (pc_out !== exp_pc || sp_out !== 3'(3 - i)) begin
                failures++;
                $display("FAIL return%0d got pc=%0h sp=%0d exp pc=%0h sp=%0d",
                         i, pc_out, sp_out, exp_pc, 3 - i);
            end
        end
        checks++;
        if (stack_empty !== 1'b1 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL drained got e=%b u=%b exp e=1 u=0",
                     stack_empty, underflow);
        end
        tick();
        checks++;
        if ({underflow, overflow, pc_out, sp_out} !== {1'b1, 1'b1, 8'h00, 3'd0}) begin
            failures++;
            $display("FAIL underflow got u=%b o=%b pc=%0h sp=%0d exp u=1 o=1 pc=0 sp=0",
                     underflow, overflow, pc_out, sp_out);
        end
        clr_ctl();
    endtask

    task automatic test_simul_clear();
        do_reset();
        pc_mux_sel = 1; inc = 1;
        repeat (7) tick();
        clr_ctl();
        push = 1; stack_we = 1;
        tick();
        clr_ctl();
        pc_mux_sel = 1; inc = 1;
        repeat (2) tick();
        clr_ctl();
        push = 1; stack_we = 1; pop = 1; stack_re = 1;
        tick();
        checks++;
        if ({sp_out, overflow, underflow, pc_out} !== {3'd1, 1'b0, 1'b0, 8'h09}) begin
            failures++;
            $display("FAIL pushpop got sp=%0d o=%b u=%b pc=%0h exp sp=1 o=0 u=0 pc=9",
                     sp_out, overflow, underflow, pc_out);
        end
        clr_ctl();
        pc_mux_sel = 1; inc = 1;
        a_mux_sel = 2'b01; b_mux_sel = 2'b10;
        rsel = 1; rce = 1; out_ce = 1; oen = 1;
        tick();
        checks++;
        if (r_out !== 8'h09 || y_out !== 8'h09) begin
            failures++;
            $display("FAIL replaced_top got r=%0h y=%0h exp r=9 y=9",
                     r_out, y_out);
        end
        clr_ctl();
        a_mux_sel = 2'b10; b_mux_sel = 2'b01; rsel = 1; rce = 1;
        pop = 1; stack_re = 1;
        tick();
        tick();
        checks++;
        if ({r_out, sp_out, underflow} !== {8'h00, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL pop_to_empty got r=%0h sp=%0d u=%b exp r=0 sp=0 u=1",
                     r_out, sp_out, underflow);
        end
        clr_ctl();
        oen = 1;
        #1;
        checks++;
        if (y_out !== 8'h09) begin
            failures++; $display("FAIL y_before_clr got=%0h exp=9", y_out);
        end
        rst = 1; oen = 0; pc_mux_sel = 1; inc = 1;
        push = 1; stack_we = 1; out_ce = 1; b_mux_sel = 2'b11; d_in = 8'h55;
        #1;
        checks++;
        if (y_out !== 8'h00) begin
            failures++; $display("FAIL oen_off got=%0h exp=0", y_out);
        end
        tick();
        clr_ctl();
        oen = 1;
        #1;
        checks++;
        if ({pc_out, r_out, y_out, sp_out, overflow, underflow, stack_empty}
            !== {8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rst_clear got pc=%0h r=%0h y=%0h sp=%0d o=%b u=%b e=%b",
                     pc_out, r_out, y_out, sp_out, overflow, underflow, stack_empty);
        end
        clr_ctl();
    endtask

    initial begin
        clr_ctl();
        reset = 1;
        test_reset();
        test_fetch_pc();
        test_adder_wrap();
        test_idle();
        test_stack_fill();
        test_return_underflow();
        test_simul_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sequencer_datapath.md
Name: sequencer_datapath

Overview:
- Microprogram sequencer datapath, directly downstream of the instruction decoder.
- Consumes the decoder's control strobes and holds the sequencer's architectural state:
  - program counter (PC)
  - R register
  - output register Y
  - LIFO return stack
- Produces the next microaddress (y_out) plus stack status flags back to the control side.

Parameters:
AW, 8, width of PC, R, Y, D input and stack entries
DEPTH, 4, number of stack entries (power of two, >=2)
SPW, 3, stack pointer width; must satisfy 2^SPW > DEPTH

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
d_in  in  AW  direct data/branch operand D
cen  in  1  adder carry-in
rst  in  1  control-level synchronous clear (decoder strobe)
oen  in  1  output enable for y_out
inc  in  1  PC increment enable
rsel  in  1  R source: 1=adder sum, 0=d_in
rce  in  1  R load enable
pc_mux_sel  in  1  PC source: 1=incrementer path, 0=stack/hold path
a_mux_sel  in  2  A operand: 00=R, 01=stack top, 10/11=zero
b_mux_sel  in  2  B operand: 00=PC, 01=stack top, 10=zero, 11=d_in
push  in  1  stack push request
pop  in  1  stack pop request
src_sel  in  1  with pc_mux_sel=0: 1=load PC from stack top, 0=hold PC
stack_we  in  1  stack write strobe (qualifies push)
stack_re  in  1  stack read strobe (qualifies pop)
out_ce  in  1  Y register load enable
y_out  out  AW  oen ? Y : 0
pc_out  out  AW  current PC
r_out  out  AW  current R
sp_out  out  SPW  stack entry count (0..DEPTH)
stack_empty  out  1  sp_out==0
stack_full  out  1  sp_out==DEPTH
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset values:
  - PC, R, Y, sp, all stack entries, overflow, underflow = 0.
  - stack_empty=1, stack_full=0, y_out=0.
- Priority each edge: reset > rst > normal operation. rst has exactly the same effect as reset.
- Stack top = stack[sp-1]; reads as 0 when empty. Top is combinational from current state.
- Adder: sum = A + B + cen, truncated to AW bits (carry-out discarded, wraps). Combinational from current-cycle register values.
- Y: if out_ce, Y <= sum; else hold. y_out is combinational: oen ? Y : 0. Zero latency from oen.
- R: if rce, R <= (rsel ? sum : d_in); else hold.
- PC:
  - pc_mux_sel=1: PC <= PC + inc (wraps at 2^AW).
  - pc_mux_sel=0, src_sel=1: PC <= stack top.
  - pc_mux_sel=0, src_sel=0: PC holds.
- Effective push = push & stack_we; effective pop = pop & stack_re. Strobes without the qualifier are no-ops.
- Push (not full): stack[sp] <= current PC (pre-increment value), sp <= sp+1.
- Pop (not empty): sp <= sp-1.
  - When pc_mux_sel=0 and src_sel=1 in the same cycle, PC takes the pre-pop top.
- Push and pop in the same cycle:
  - empty: behaves as a plain push.
  - otherwise: stack[sp-1] <= PC, sp unchanged (replace top).
  - No overflow or underflow is flagged in either case.
- Push while full (no pop): ignored; overflow <= 1.
- Pop while empty (no push): ignored; underflow <= 1.
- overflow/underflow remain set until reset or rst.
- All operand reads use pre-edge values. R, Y, PC and the stack may all update in the same cycle without interaction.
- An all-zero control vector (the decoder's disabled output) holds all state; y_out=0.

Test Plan:
1. Reset: assert reset 2 cycles with random controls -> pc_out=0, r_out=0, y_out=0, sp_out=0, stack_empty=1, overflow=underflow=0.
2. Fetch PC->R: pc_mux_sel=1, inc=1 for 3 cycles (PC=3); then a=10, b=00, rsel=1, rce=1, out_ce=1, oen=1, inc=1 -> r_out=3, y_out=3, pc_out=4.
3. Fetch R+D with wrap:
   - R=0x03, d_in=0x10, a=00, b=11, cen=1, rsel=1, rce=1, out_ce=1 -> r_out=0x14, y_out=0x14.
   - Then R=0xFF, d_in=0x00, cen=1 -> r_out=0x00.
   - PC=0xFF with inc -> 0x00.
4. Stack fill/overflow, DEPTH=4:
   - Push at PC=1,2,3,4 -> sp_out=4, stack_full=1.
   - 5th push at PC=5 -> sp_out=4, overflow=1, entry 3 still 4.
5. Return/underflow:
   - From full, pop+stack_re with pc_mux_sel=0, src_sel=1 four times -> PC sequence 4, 3, 2, 1; stack_empty=1.
   - 5th pop -> underflow=1, PC loads 0.
6. Simultaneous/clear:
   - Stack holds [7]; push+pop at PC=9 -> sp_out=1, top=9.
   - Then rst=1 mid-run -> PC, R, Y, sp and both flags = 0 next edge; oen=0 forces y_out=0 the same cycle.
